// File: rtl/image_pipe_rst_seq.sv
// image_pipe_rst_seq: staggered per-stage reset sequencer with CPU soft reset drained via req/idle handshake
module image_pipe_rst_seq #(
  parameter int NUM_STAGES    = 4,
  parameter int ASSERT_CYCLES = 16,
  parameter int STAGE_GAP     = 4,
  parameter int DRAIN_TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  s_rst_n,
  input  logic                  reg_cpreg_cpu_rst_n,
  input  logic                  pipe_idle,
  output logic [NUM_STAGES-1:0] pipe_rst_n,
  output logic                  drain_req,
  output logic                  rst_busy,
  output logic                  rst_done,
  output logic                  drain_tmo,
  output logic [7:0]            soft_rst_cnt
);
  localparam int CMAX = (ASSERT_CYCLES > STAGE_GAP)
                      ? ((ASSERT_CYCLES > DRAIN_TIMEOUT) ? ASSERT_CYCLES : DRAIN_TIMEOUT)
                      : ((STAGE_GAP > DRAIN_TIMEOUT) ? STAGE_GAP : DRAIN_TIMEOUT);
  localparam int CW = $clog2(CMAX) + 1;
  localparam int SW = $clog2(NUM_STAGES) + 1;
  localparam logic [CW-1:0] A_END = CW'(ASSERT_CYCLES - 1);
  localparam logic [CW-1:0] G_END = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] T_END = CW'(DRAIN_TIMEOUT - 1);
  localparam logic [SW-1:0] S_END = SW'(NUM_STAGES - 1);
  typedef enum logic [1:0] {HOLD, RELEASE, RUN, DRAIN} state_t;
  state_t          state;
  logic [CW-1:0]   cnt;
  logic [SW-1:0]   stage_idx;
  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      state        <= HOLD;
      cnt          <= '0;
      stage_idx    <= '0;
      pipe_rst_n   <= '0;
      drain_req    <= 1'b0;
      rst_busy     <= 1'b1;
      rst_done     <= 1'b0;
      drain_tmo    <= 1'b0;
      soft_rst_cnt <= '0;
    end else begin
      rst_done <= 1'b0;
      case (state)
        HOLD: begin
          pipe_rst_n <= '0;
          rst_busy   <= 1'b1;
          if (!reg_cpreg_cpu_rst_n) cnt <= '0;
          else if (cnt == A_END) begin
            state     <= RELEASE;
            cnt       <= '0;
            stage_idx <= '0;
          end else cnt <= cnt + 1'b1;
        end
        RELEASE: begin
          // a soft reset mid-release needs no drain: the pipe never ran
          if (!reg_cpreg_cpu_rst_n) begin
            state      <= HOLD;
            pipe_rst_n <= '0;
            cnt        <= '0;
          end else if (cnt == G_END) begin
            pipe_rst_n <= pipe_rst_n | (NUM_STAGES'(1) << stage_idx);
            cnt        <= '0;
            stage_idx  <= (stage_idx == S_END) ? '0 : stage_idx + 1'b1;
            if (stage_idx == S_END) begin
              state    <= RUN;
              rst_done <= 1'b1;
              rst_busy <= 1'b0;
            end
          end else cnt <= cnt + 1'b1;
        end
        RUN: begin
          pipe_rst_n <= '1;
          rst_busy   <= !reg_cpreg_cpu_rst_n;
          if (!reg_cpreg_cpu_rst_n) begin
            state        <= DRAIN;
            drain_req    <= 1'b1;
            cnt          <= '0;
            soft_rst_cnt <= (soft_rst_cnt == 8'hff) ? soft_rst_cnt : soft_rst_cnt + 1'b1;
          end
        end
        DRAIN: begin
          // idle wins over a coincident timeout, so the timeout flag only marks a real stall
          if (pipe_idle || cnt == T_END) begin
            state      <= HOLD;
            drain_req  <= 1'b0;
            pipe_rst_n <= '0;
            cnt        <= '0;
            drain_tmo  <= drain_tmo | !pipe_idle;
          end else cnt <= cnt + 1'b1;
        end
        default: state <= HOLD;
      endcase
    end
  end
endmodule

// File: tb/tb_image_pipe_rst_seq.sv
// tb_image_pipe_rst_seq: directed checks of release timing, drain, timeout, abort and saturation
module tb_image_pipe_rst_seq;
  localparam int A = 16, G = 4, N = 4, LAST = A + N * G;
  logic clk = 1'b0;
  logic s_rst_n, cpu_rst_n, pipe_idle;
  logic [N-1:0] pipe_rst_n;
  logic drain_req, rst_busy, rst_done, drain_tmo;
  logic [7:0] soft_rst_cnt;
  logic s_rst_n2, cpu_rst_n2, pipe_idle2;
  logic [N-1:0] pipe_rst_n2;
  logic drain_req2, rst_busy2, rst_done2, drain_tmo2;
  logic [7:0] soft_rst_cnt2;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  image_pipe_rst_seq dut (
    .clk(clk), .s_rst_n(s_rst_n), .reg_cpreg_cpu_rst_n(cpu_rst_n), .pipe_idle(pipe_idle),
    .pipe_rst_n(pipe_rst_n), .drain_req(drain_req), .rst_busy(rst_busy), .rst_done(rst_done),
    .drain_tmo(drain_tmo), .soft_rst_cnt(soft_rst_cnt)
  );
  image_pipe_rst_seq #(.DRAIN_TIMEOUT(8)) dut8 (
    .clk(clk), .s_rst_n(s_rst_n2), .reg_cpreg_cpu_rst_n(cpu_rst_n2), .pipe_idle(pipe_idle2),
    .pipe_rst_n(pipe_rst_n2), .drain_req(drain_req2), .rst_busy(rst_busy2), .rst_done(rst_done2),
    .drain_tmo(drain_tmo2), .soft_rst_cnt(soft_rst_cnt2)
  );
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_reset;
    s_rst_n = 0; cpu_rst_n = 1; pipe_idle = 0;
    s_rst_n2 = 0; cpu_rst_n2 = 1; pipe_idle2 = 0;
    tick(5);
    checks++; if (pipe_rst_n !== 4'h0) begin errors++; $display("FAIL reset_pipe_rst_n got %h exp 0", pipe_rst_n); end
    checks++; if (drain_req !== 1'b0) begin errors++; $display("FAIL reset_drain_req got %b exp 0", drain_req); end
    checks++; if (rst_busy !== 1'b1) begin errors++; $display("FAIL reset_rst_busy got %b exp 1", rst_busy); end
    checks++; if (rst_done !== 1'b0) begin errors++; $display("FAIL reset_rst_done got %b exp 0", rst_done); end
    checks++; if (drain_tmo !== 1'b0) begin errors++; $display("FAIL reset_drain_tmo got %b exp 0", drain_tmo); end
    checks++; if (soft_rst_cnt !== 8'd0) begin errors++; $display("FAIL reset_soft_cnt got %0d exp 0", soft_rst_cnt); end
  endtask
  task automatic test_release;
    logic [N-1:0] exp_p;
    s_rst_n = 1;
    for (int e = 1; e <= LAST + 1; e++) begin
      tick(1);
      exp_p = '0;
      for (int i = 0; i < N; i++) if (e >= A + (i + 1) * G) exp_p[i] = 1'b1;
      checks++; if (pipe_rst_n !== exp_p) begin errors++; $display("FAIL release_pipe_rst_n edge %0d got %h exp %h", e, pipe_rst_n, exp_p); end
      checks++; if (rst_done !== (e == LAST)) begin errors++; $display("FAIL release_rst_done edge %0d got %b exp %b", e, rst_done, e == LAST); end
      checks++; if (rst_busy !== (e < LAST)) begin errors++; $display("FAIL release_rst_busy edge %0d got %b exp %b", e, rst_busy, e < LAST); end
    end
  endtask
  task automatic test_soft_drain;
    cpu_rst_n = 0; tick(1);
    checks++; if (drain_req !== 1'b1) begin errors++; $display("FAIL drain_req_rise got %b exp 1", drain_req); end
    checks++; if (soft_rst_cnt !== 8'd1) begin errors++; $display("FAIL drain_soft_cnt got %0d exp 1", soft_rst_cnt); end
    checks++; if (rst_busy !== 1'b1) begin errors++; $display("FAIL drain_busy got %b exp 1", rst_busy); end
    tick(2); cpu_rst_n = 1; tick(7);
    checks++; if (drain_req !== 1'b1 || pipe_rst_n !== 4'hf) begin errors++; $display("FAIL drain_latched got req %b rst %h exp 1 f", drain_req, pipe_rst_n); end
    pipe_idle = 1; tick(1); pipe_idle = 0;
    checks++; if (drain_req !== 1'b0 || pipe_rst_n !== 4'h0) begin errors++; $display("FAIL drain_idle_exit got req %b rst %h exp 0 0", drain_req, pipe_rst_n); end
    tick(A + G - 1);
    checks++; if (pipe_rst_n !== 4'h0) begin errors++; $display("FAIL drain_restart_early got %h exp 0", pipe_rst_n); end
    tick(1);
    checks++; if (pipe_rst_n !== 4'h1) begin errors++; $display("FAIL drain_restart_stage0 got %h exp 1", pipe_rst_n); end
    tick(LAST - A - G);
    checks++; if (pipe_rst_n !== 4'hf || rst_done !== 1'b1) begin errors++; $display("FAIL drain_restart_done got %h/%b exp f/1", pipe_rst_n, rst_done); end
    checks++; if (drain_tmo !== 1'b0) begin errors++; $display("FAIL drain_no_tmo got %b exp 0", drain_tmo); end
  endtask
  task automatic test_timeout;
    cpu_rst_n = 0; tick(1); cpu_rst_n = 1;
    tick(255);
    checks++; if (drain_req !== 1'b1 || drain_tmo !== 1'b0) begin errors++; $display("FAIL tmo_before got req %b tmo %b exp 1 0", drain_req, drain_tmo); end
    tick(1);
    checks++; if (pipe_rst_n !== 4'h0 || drain_req !== 1'b0 || drain_tmo !== 1'b1) begin errors++; $display("FAIL tmo_fire got rst %h req %b tmo %b exp 0 0 1", pipe_rst_n, drain_req, drain_tmo); end
    tick(LAST);
    checks++; if (rst_busy !== 1'b0 || pipe_rst_n !== 4'hf) begin errors++; $display("FAIL tmo_rerun got busy %b rst %h exp 0 f", rst_busy, pipe_rst_n); end
    cpu_rst_n = 0; tick(1); cpu_rst_n = 1; pipe_idle = 1; tick(1); pipe_idle = 0; tick(LAST);
    checks++; if (drain_tmo !== 1'b1) begin errors++; $display("FAIL tmo_sticky got %b exp 1", drain_tmo); end
    checks++; if (soft_rst_cnt !== 8'd3) begin errors++; $display("FAIL tmo_soft_cnt got %0d exp 3", soft_rst_cnt); end
    s_rst_n = 0; tick(1);
    checks++; if (drain_tmo !== 1'b0 || soft_rst_cnt !== 8'd0) begin errors++; $display("FAIL tmo_clear got tmo %b cnt %0d exp 0 0", drain_tmo, soft_rst_cnt); end
  endtask
  task automatic test_mid_release;
    s_rst_n = 1; tick(A + 2 * G + 1);
    checks++; if (pipe_rst_n !== 4'h3) begin errors++; $display("FAIL mid_before got %h exp 3", pipe_rst_n); end
    cpu_rst_n = 0; tick(1);
    checks++; if (pipe_rst_n !== 4'h0 || drain_req !== 1'b0 || rst_busy !== 1'b1) begin errors++; $display("FAIL mid_abort got rst %h req %b busy %b exp 0 0 1", pipe_rst_n, drain_req, rst_busy); end
    checks++; if (soft_rst_cnt !== 8'd0) begin errors++; $display("FAIL mid_soft_cnt got %0d exp 0", soft_rst_cnt); end
    tick(A + G + 5);
    checks++; if (pipe_rst_n !== 4'h0) begin errors++; $display("FAIL mid_hold_while_low got %h exp 0", pipe_rst_n); end
    cpu_rst_n = 1; tick(A + G - 1);
    checks++; if (pipe_rst_n !== 4'h0) begin errors++; $display("FAIL mid_restart_early got %h exp 0", pipe_rst_n); end
    tick(LAST - A - G + 1);
    checks++; if (pipe_rst_n !== 4'hf || rst_done !== 1'b1) begin errors++; $display("FAIL mid_restart_done got %h/%b exp f/1", pipe_rst_n, rst_done); end
  endtask
  task automatic test_sys_rst_drain_and_saturate;
    cpu_rst_n = 0; tick(1); cpu_rst_n = 1; tick(5);
    checks++; if (drain_req !== 1'b1 || soft_rst_cnt !== 8'd1) begin errors++; $display("FAIL sysd_in_drain got req %b cnt %0d exp 1 1", drain_req, soft_rst_cnt); end
    s_rst_n = 0; tick(1);
    checks++; if (drain_req !== 1'b0 || pipe_rst_n !== 4'h0 || soft_rst_cnt !== 8'd0) begin errors++; $display("FAIL sysd_override got req %b rst %h cnt %0d exp 0 0 0", drain_req, pipe_rst_n, soft_rst_cnt); end
    s_rst_n = 1; tick(LAST);
    for (int k = 0; k < 255; k++) begin
      cpu_rst_n = 0; tick(1); cpu_rst_n = 1; pipe_idle = 1; tick(1); pipe_idle = 0; tick(LAST);
    end
    checks++; if (soft_rst_cnt !== 8'd255) begin errors++; $display("FAIL sat_255 got %0d exp 255", soft_rst_cnt); end
    cpu_rst_n = 0; tick(1); cpu_rst_n = 1; pipe_idle = 1; tick(1); pipe_idle = 0; tick(LAST);
    checks++; if (soft_rst_cnt !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d exp 255", soft_rst_cnt); end
    checks++; if (rst_busy !== 1'b0) begin errors++; $display("FAIL sat_run got busy %b exp 0", rst_busy); end
  endtask
  task automatic test_idle_vs_timeout;
    s_rst_n2 = 1; tick(LAST);
    checks++; if (pipe_rst_n2 !== 4'hf) begin errors++; $display("FAIL tie_run got %h exp f", pipe_rst_n2); end
    cpu_rst_n2 = 0; tick(1); cpu_rst_n2 = 1; tick(7);
    checks++; if (drain_req2 !== 1'b1) begin errors++; $display("FAIL tie_still_drain got %b exp 1", drain_req2); end
    pipe_idle2 = 1; tick(1); pipe_idle2 = 0;
    checks++; if (drain_req2 !== 1'b0 || pipe_rst_n2 !== 4'h0) begin errors++; $display("FAIL tie_exit got req %b rst %h exp 0 0", drain_req2, pipe_rst_n2); end
    checks++; if (drain_tmo2 !== 1'b0) begin errors++; $display("FAIL tie_tmo got %b exp 0", drain_tmo2); end
    checks++; if (soft_rst_cnt2 !== 8'd1) begin errors++; $display("FAIL tie_soft_cnt got %0d exp 1", soft_rst_cnt2); end
  endtask
  initial begin
    test_reset;
    test_release;
    test_soft_drain;
    test_timeout;
    test_mid_release;
    test_sys_rst_drain_and_saturate;
    test_idle_vs_timeout;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
